// File: rtl/gpio_cmd_ctrl.sv
// gpio_cmd_ctrl: decodes toggle-strobed GPIO command words into kernel load,
// pixel RAM writes, convolution start and result readback, and reports
// status plus an ack toggle back on the GPIO input word.
module gpio_cmd_ctrl #(
    parameter int BIT_LEN    = 8,
    parameter int CONV_LEN   = 20,
    parameter int M_LEN      = 3,
    parameter int NB_ADDRESS = 10,
    parameter int GPIO_D     = 32
) (
    input  logic                  CLK100MHZ,
    input  logic                  i_rst_n,
    input  logic [GPIO_D-1:0]     gpio_o_data_tri_o,
    output logic [GPIO_D-1:0]     gpio_i_data_tri_i,
    output logic                  o_led,
    output logic                  o_ker_we,
    output logic [3:0]            o_ker_idx,
    output logic [BIT_LEN-1:0]    o_ker_data,
    output logic                  o_ram_we,
    output logic [NB_ADDRESS-1:0] o_ram_addr,
    output logic [BIT_LEN-1:0]    o_ram_data,
    output logic                  o_rd_en,
    input  logic [CONV_LEN-1:0]   i_rd_data,
    output logic                  o_conv_start,
    input  logic                  i_conv_done
);

    localparam logic [3:0] KN       = 4'(M_LEN * M_LEN);
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_SRST  = 3'd1;
    localparam logic [2:0] OP_KER   = 3'd2;
    localparam logic [2:0] OP_PIX   = 3'd3;
    localparam logic [2:0] OP_START = 3'd4;
    localparam logic [2:0] OP_READ  = 3'd5;

    typedef enum logic [1:0] {IDLE, RUN, RD} state_t;

    state_t                state, state_nxt;
    logic                  armed, strb_q, ack_q, err_q, full_q, rd_phase;
    logic [3:0]            kidx;
    logic [NB_ADDRESS-1:0] paddr;
    logic [CONV_LEN-1:0]   result;

    logic                  strb, cmd_vld, busy, rd_done;
    logic [2:0]            opcode;
    logic [BIT_LEN-1:0]    pay_b;
    logic [NB_ADDRESS-1:0] pay_a;
    logic                  do_ker, do_pix, do_start, do_read, do_srst, set_err;

    assign strb   = gpio_o_data_tri_o[GPIO_D-1];
    assign opcode = gpio_o_data_tri_o[2:0];
    assign pay_b  = gpio_o_data_tri_o[BIT_LEN+7:8];
    assign pay_a  = gpio_o_data_tri_o[NB_ADDRESS+7:8];

    logic unused_bits;
    assign unused_bits = ^{gpio_o_data_tri_o[GPIO_D-2:NB_ADDRESS+8], gpio_o_data_tri_o[7:3]};

    // A toggle seen during RD is not consumed, so it stays pending until IDLE.
    // The first cycle after reset only re-syncs the strobe copy (no command).
    assign cmd_vld = armed && (strb != strb_q) && (state != RD);
    assign busy    = (state != IDLE);
    assign rd_done = (state == RD) && rd_phase;
    assign o_led   = busy;

    // State register
    always_ff @(posedge CLK100MHZ or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Command decode and next state
    always_comb begin
        state_nxt = state;
        do_ker    = 1'b0;
        do_pix    = 1'b0;
        do_start  = 1'b0;
        do_read   = 1'b0;
        do_srst   = 1'b0;
        set_err   = 1'b0;
        case (state)
            IDLE: if (cmd_vld) begin
                case (opcode)
                    OP_NOP:  ;
                    OP_SRST: do_srst = 1'b1;
                    OP_KER:  if (kidx == KN) set_err = 1'b1; else do_ker = 1'b1;
                    OP_PIX:  if (full_q) set_err = 1'b1; else do_pix = 1'b1;
                    OP_START: begin
                        if (kidx == KN && (paddr != '0 || full_q)) begin
                            do_start  = 1'b1;
                            state_nxt = RUN;
                        end else begin
                            set_err = 1'b1;
                        end
                    end
                    OP_READ: begin
                        do_read   = 1'b1;
                        state_nxt = RD;
                    end
                    default: set_err = 1'b1;
                endcase
            end
            RUN: begin
                if (cmd_vld && opcode == OP_SRST) do_srst = 1'b1;
                else if (cmd_vld && opcode != OP_NOP) set_err = 1'b1;
                if (i_conv_done) state_nxt = IDLE;
            end
            RD: if (rd_phase) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (do_srst) state_nxt = IDLE;
    end

    // Counters, flags, strobes and readback capture
    always_ff @(posedge CLK100MHZ or negedge i_rst_n) begin
        if (!i_rst_n) begin
            armed        <= 1'b0;
            strb_q       <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            full_q       <= 1'b0;
            rd_phase     <= 1'b0;
            kidx         <= '0;
            paddr        <= '0;
            result       <= '0;
            o_ker_we     <= 1'b0;
            o_ker_idx    <= '0;
            o_ker_data   <= '0;
            o_ram_we     <= 1'b0;
            o_ram_addr   <= '0;
            o_ram_data   <= '0;
            o_rd_en      <= 1'b0;
            o_conv_start <= 1'b0;
        end else begin
            armed        <= 1'b1;
            o_ker_we     <= do_ker;
            o_ram_we     <= do_pix;
            o_rd_en      <= do_read;
            o_conv_start <= do_start;
            rd_phase     <= (state == RD) && !rd_phase;
            if (!armed || cmd_vld) strb_q <= strb;
            if ((cmd_vld && !do_read) || rd_done) ack_q <= ~ack_q;
            if (set_err) err_q <= 1'b1;
            if (do_ker) begin
                o_ker_idx  <= kidx;
                o_ker_data <= pay_b;
                kidx       <= kidx + 4'd1;
            end
            if (do_pix) begin
                o_ram_addr <= paddr;
                o_ram_data <= pay_b;
                if (&paddr) full_q <= 1'b1;
                else        paddr  <= paddr + 1'b1;
            end
            if (do_read) o_ram_addr <= pay_a;
            if (rd_done) result <= i_rd_data;
            if (do_srst) begin
                kidx   <= '0;
                paddr  <= '0;
                full_q <= 1'b0;
                err_q  <= 1'b0;
            end
        end
    end

    // Response word assembly
    always_comb begin
        gpio_i_data_tri_i                 = '0;
        gpio_i_data_tri_i[CONV_LEN-1:0]   = result;
        gpio_i_data_tri_i[27:24]          = kidx;
        gpio_i_data_tri_i[28]             = full_q;
        gpio_i_data_tri_i[29]             = err_q;
        gpio_i_data_tri_i[30]             = busy;
        gpio_i_data_tri_i[31]             = ack_q;
    end

endmodule

// File: tb/tb_gpio_cmd_ctrl.sv
// tb_gpio_cmd_ctrl: directed and randomized commands checked against a
// command-level model of the controller; result RAM modelled as an array.
module tb_gpio_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] word = 32'h8000_0001;
    logic [31:0] resp;
    logic        led, ker_we, ram_we, rd_en, conv_start, conv_done = 1'b0;
    logic [3:0]  ker_idx;
    logic [7:0]  ker_data, ram_data;
    logic [9:0]  ram_addr;
    logic [19:0] rd_data = '0;

    gpio_cmd_ctrl dut (
        .CLK100MHZ(clk), .i_rst_n(rst_n),
        .gpio_o_data_tri_o(word), .gpio_i_data_tri_i(resp), .o_led(led),
        .o_ker_we(ker_we), .o_ker_idx(ker_idx), .o_ker_data(ker_data),
        .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_data(ram_data),
        .o_rd_en(rd_en), .i_rd_data(rd_data),
        .o_conv_start(conv_start), .i_conv_done(conv_done)
    );

    always #5 clk = ~clk;

    // Result RAM: registered read, data one cycle after the read strobe
    logic [19:0] rmem [1024];
    always @(posedge clk) if (rd_en) rd_data <= rmem[ram_addr];

    int n_chk = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Command-level model
    logic        m_run, m_ack, m_err, m_full;
    logic [3:0]  m_kidx;
    int          m_paddr;
    logic [19:0] m_result;

    task automatic m_reset();
        m_run = 0; m_ack = 0; m_err = 0; m_full = 0; m_kidx = 0; m_paddr = 0; m_result = 0;
    endtask

    function automatic logic [31:0] exp_resp(input logic busy);
        return {m_ack, busy, m_err, m_full, m_kidx, 4'h0, m_result};
    endfunction

    task automatic put(input int op, input logic [9:0] pay);
        word = {~word[31], 13'h0, pay, 5'h0, 3'(op)};
    endtask

    task automatic cmd(input int op, input logic [9:0] pay, input logic dn);
        logic e_kwe, e_pwe, e_st, rd_go;
        logic [3:0] e_kidx;
        logic [9:0] e_addr;
        e_kwe = 0; e_pwe = 0; e_st = 0; rd_go = 0; e_kidx = 0; e_addr = 0;
        @(negedge clk);
        put(op, pay);
        conv_done = dn;
        if (m_run) begin
            if (op == 1) begin
                m_kidx = 0; m_paddr = 0; m_full = 0; m_err = 0; m_run = 0;
            end else begin
                if (op != 0) m_err = 1;
                if (dn) m_run = 0;
            end
        end else begin
            case (op)
                1: begin m_kidx = 0; m_paddr = 0; m_full = 0; m_err = 0; end
                2: if (m_kidx == 9) m_err = 1;
                   else begin e_kwe = 1; e_kidx = m_kidx; m_kidx = m_kidx + 1; end
                3: if (m_full) m_err = 1;
                   else begin
                       e_pwe = 1; e_addr = 10'(m_paddr);
                       if (m_paddr == 1023) m_full = 1; else m_paddr++;
                   end
                4: if (m_kidx == 9 && (m_paddr != 0 || m_full)) begin e_st = 1; m_run = 1; end
                   else m_err = 1;
                5: rd_go = 1;
                6, 7: m_err = 1;
                default: ;
            endcase
        end
        if (!rd_go) m_ack = ~m_ack;
        @(posedge clk); #1;
        conv_done = 0;
        chk("ker_we", 32'(ker_we), 32'(e_kwe));
        if (e_kwe) begin
            chk("ker_idx", 32'(ker_idx), 32'(e_kidx));
            chk("ker_data", 32'(ker_data), 32'(pay[7:0]));
        end
        chk("ram_we", 32'(ram_we), 32'(e_pwe));
        if (e_pwe) begin
            chk("ram_addr", 32'(ram_addr), 32'(e_addr));
            chk("ram_data", 32'(ram_data), 32'(pay[7:0]));
        end
        chk("conv_start", 32'(conv_start), 32'(e_st));
        chk("rd_en", 32'(rd_en), 32'(rd_go));
        if (rd_go) chk("rd_addr", 32'(ram_addr), 32'(pay));
        chk("resp", resp, exp_resp(m_run | rd_go));
        chk("led", 32'(led), 32'(m_run | rd_go));
        if (rd_go) begin
            @(posedge clk); #1;
            chk("rd_hold", resp, exp_resp(1'b1));
            chk("rd_en_off", 32'(rd_en), 32'd0);
            @(posedge clk); #1;
            m_result = rmem[pay];
            m_ack = ~m_ack;
            chk("rd_result", resp, exp_resp(1'b0));
        end
    endtask

    task automatic done_pulse();
        @(negedge clk);
        conv_done = 1;
        if (m_run) m_run = 0;
        @(posedge clk); #1;
        conv_done = 0;
        chk("done_resp", resp, exp_resp(m_run));
        chk("done_led", 32'(led), 32'(m_run));
    endtask

    initial begin
        logic [9:0] a;
        int r, op;
        for (int i = 0; i < 1024; i++) rmem[i] = 20'($urandom);
        rmem[3] = 20'hABCDE;
        m_reset();

        // Reset with a strobe already high on the command word
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp", resp, 32'h0);
        chk("rst_led", 32'(led), 32'd0);
        @(negedge clk); rst_n = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_resp", resp, 32'h0);
        chk("post_rst_ker_we", 32'(ker_we), 32'd0);

        // Kernel load 1..9, then an over-run
        for (int i = 1; i <= 9; i++) cmd(2, 10'(i), 0);
        chk("kidx9", 32'(resp[27:24]), 32'd9);
        cmd(2, 10'd10, 0);
        chk("ker_err", 32'(resp[29]), 32'd1);

        // START with only 5 coefficients, then SOFT_RST
        cmd(1, 0, 0);
        for (int i = 0; i < 5; i++) cmd(2, 10'($urandom_range(0, 255)), 0);
        cmd(4, 0, 0);
        chk("start5_err", 32'(resp[29]), 32'd1);
        cmd(1, 0, 0);
        chk("srst_clr", 32'(resp[29:24]), 32'd0);

        // Good START, LOAD_PIX blocked in RUN, done returns to IDLE
        for (int i = 0; i < 9; i++) cmd(2, 10'($urandom_range(0, 255)), 0);
        for (int i = 0; i < 4; i++) cmd(3, 10'($urandom_range(0, 255)), 0);
        cmd(4, 0, 0);
        chk("run_led", 32'(led), 32'd1);
        cmd(3, 10'h55, 0);
        cmd(5, 10'h7, 0);
        done_pulse();
        done_pulse();

        // done together with SOFT_RST while running
        cmd(1, 0, 0);
        for (int i = 0; i < 9; i++) cmd(2, 10'(i), 0);
        cmd(3, 10'h1, 0);
        cmd(4, 0, 0);
        cmd(1, 0, 1);

        // READ at address 3
        cmd(5, 10'd3, 0);
        chk("read3", 32'(resp[19:0]), 32'hABCDE);

        // A toggle during RD is held and taken on the first IDLE cycle
        a = 10'($urandom_range(0, 1023));
        @(negedge clk); put(5, a);
        @(posedge clk); #1;
        chk("pend_rd_en", 32'(rd_en), 32'd1);
        @(negedge clk); put(0, 0);
        @(posedge clk); #1;
        chk("pend_t1", resp, exp_resp(1'b1));
        @(posedge clk); #1;
        m_result = rmem[a]; m_ack = ~m_ack;
        chk("pend_t2", resp, exp_resp(1'b0));
        @(posedge clk); #1;
        m_ack = ~m_ack;
        chk("pend_t3", resp, exp_resp(1'b0));

        // Fill the pixel RAM with a counting payload, then overflow
        cmd(1, 0, 0);
        for (int i = 0; i < 1024; i++) cmd(3, 10'(i), 0);
        chk("full", 32'(resp[28]), 32'd1);
        chk("full_noerr", 32'(resp[29]), 32'd0);
        cmd(3, 10'h3FF, 0);
        chk("full_err", 32'(resp[29]), 32'd1);

        // Randomized command mix
        cmd(1, 0, 0);
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 15);
            op = (r < 5) ? 2 : (r < 8) ? 3 : (r < 10) ? 4 : (r < 12) ? 5 :
                 (r == 12) ? 1 : (r == 13) ? int'($urandom_range(6, 7)) : 0;
            cmd(op, 10'($urandom_range(0, 1023)), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) done_pulse();
        end

        // Asynchronous reset in mid-operation, no pulses after release
        for (int i = 0; i < 9; i++) cmd(2, 10'(i), 0);
        cmd(4, 0, 0);
        #3 rst_n = 0;
        #1;
        chk("async_rst_resp", resp, 32'h0);
        chk("async_rst_led", 32'(led), 32'd0);
        m_reset();
        word[31] = 1'b1;
        @(negedge clk); rst_n = 1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rel_pulses", {28'h0, ker_we, ram_we, rd_en, conv_start}, 32'h0);
            chk("rel_resp", resp, 32'h0);
        end
        cmd(0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/gpio_cmd_ctrl.md
# gpio_cmd_ctrl

Command controller between the MicroBlaze GPIO pair and the convolution datapath. It decodes 32-bit command words written by software on the GPIO output port and drives the kernel load, the pixel RAM writes, convolution start and result readback. It returns data and status on the GPIO input port, and acknowledges every accepted command with a toggle bit. Software uses this block as its only path into the 2D convolution engine.

## Interface

Parameters:
- BIT_LEN, 8, pixel and coefficient width.
- CONV_LEN, 20, convolution result width.
- M_LEN, 3, kernel side; the kernel has M_LEN*M_LEN coefficients.
- NB_ADDRESS, 10, pixel/result RAM address width.
- GPIO_D, 32, GPIO word width.

Ports:
- CLK100MHZ, in, 1, single system clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- gpio_o_data_tri_o, in, GPIO_D, command word from the micro.
- gpio_i_data_tri_i, out, GPIO_D, response word to the micro.
- o_led, out, 1, busy indicator.
- o_ker_we, out, 1, kernel coefficient write strobe.
- o_ker_idx, out, 4, kernel coefficient index.
- o_ker_data, out, BIT_LEN, coefficient value.
- o_ram_we, out, 1, pixel RAM write strobe.
- o_ram_addr, out, NB_ADDRESS, pixel write address or result read address.
- o_ram_data, out, BIT_LEN, pixel value.
- o_rd_en, out, 1, result RAM read strobe.
- i_rd_data, in, CONV_LEN, result RAM data, valid 1 cycle after o_rd_en.
- o_conv_start, out, 1, one-cycle start pulse to the engine.
- i_conv_done, in, 1, one-cycle done pulse from the engine.

## Operation

- Command word fields: [31] strobe toggle; [2:0] opcode; [15:8] payload byte; [NB_ADDRESS+7:8] payload address.
- A command is accepted in the cycle where bit 31 differs from its registered copy. No other field change triggers a command.
- Opcodes:
  - 0 NOP: acknowledge only.
  - 1 SOFT_RST: clear all counters, the error flag and the state. Accepted in any state, including RUN.
  - 2 LOAD_KER: write the payload byte to coefficient kidx, then increment kidx. If kidx equals M_LEN*M_LEN before the write, do not write and set the error flag.
  - 3 LOAD_PIX: write the payload byte at paddr, then increment paddr. If paddr is all ones, write, set the full flag, and set the error flag on any further LOAD_PIX. Never wrap.
  - 4 START: allowed only if kidx equals M_LEN*M_LEN and paddr is nonzero or the full flag is set. On success, pulse o_conv_start and enter RUN. Otherwise set the error flag and stay in IDLE.
  - 5 READ: read the result at the payload address; enter RD.
  - 6 and 7: illegal; set the error flag.
- States:
  - IDLE: all commands are legal.
  - RUN: only SOFT_RST and NOP are legal. Any other command sets the error flag and is acknowledged without taking effect. i_conv_done moves the state to IDLE.
  - RD: lasts 2 cycles, then returns to IDLE. A strobe toggle during RD is held as pending and accepted on the first IDLE cycle.
- Response word fields:
  - [CONV_LEN-1:0]: last read result, zero-extended.
  - [27:24]: kidx.
  - [28]: full flag.
  - [29]: error flag (sticky).
  - [30]: busy (state is not IDLE).
  - [31]: ack toggle, inverted once per completed command.
- o_led = busy.

## Timing

- Reset: every output is 0, including the whole response word. State is IDLE. kidx, paddr, flags and the strobe copy are 0.
- The command is sampled at edge T.
- o_ker_we, o_ram_we, o_conv_start and o_rd_en are asserted for exactly one cycle, in cycle T+1, with their address and data outputs valid in that cycle.
- Ack for non-read commands toggles at T+1.
- READ: o_rd_en and o_ram_addr are driven at T+1. i_rd_data is captured at T+2. Result bits and ack update together at T+2, so data is never stale when ack flips.
- i_conv_done arriving in the same cycle as an accepted SOFT_RST: SOFT_RST wins and the state goes to IDLE.
- i_conv_done outside RUN is ignored.
- Reset asserted mid-operation returns the block to the reset values asynchronously. No pulse is emitted after reset releases.

## Test plan

- Reset: i_rst_n=0 with command word 0x80000001. The response word must be 0x00000000 and o_led must be 0. After release, the response must hold with no ack toggle until bit 31 toggles.
- Kernel load: 9 LOAD_KER commands with payloads 1..9. Required: o_ker_idx runs 0..8, response [27:24]=9. A 10th LOAD_KER gives no o_ker_we and sets error bit [29].
- Pixel load with counting payload (word += 0x100 and bit-31 toggle each command): o_ram_addr increments 0,1,2 and o_ram_data equals payload. After 1024 writes the full bit is 1. The 1025th write is blocked and sets error.
- START with kidx=9 and 4 pixels loaded: o_conv_start pulses once and o_led=1. A LOAD_PIX in RUN sets error with no o_ram_we. i_conv_done returns o_led to 0.
- START with kidx=5: no o_conv_start, error=1. A following SOFT_RST clears error and kidx to 0.
- READ at address 0x3 with i_rd_data=0xABCDE: o_rd_en with addr 3 at T+1. At T+2 the response bits [19:0] read 0xABCDE and ack flips.
